slice_add_sequencer: RTL and testbench

//  Multi-cycle controller that computes a WIDTH-bit unsigned sum using one external SLICE-bit adder.
//  The external adder is the team's 4-bit ripple-carry slice, combinational, with carry in/out.
//  The block feeds one SLICE-bit chunk per cycle, LSB first, and chains the carry through a register.
//  It sits between the Nexys A7 switch/button front end and the adder datapath.
//  It returns a WIDTH+1-bit result with a start/busy/done handshake.

---
 rtl/slice_add_sequencer.sv | 106 ++++++++++
 tb/tb_slice_add_sequencer.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/slice_add_sequencer.sv
// Multi-cycle WIDTH-bit unsigned adder controller that streams SLICE-bit chunks, LSB first,
// through one external combinational adder slice and chains the carry through a register.
module slice_add_sequencer #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH:0]   sum,
  output logic [SLICE-1:0] slice_a,
  output logic [SLICE-1:0] slice_b,
  output logic             slice_cin,
  input  logic [SLICE-1:0] slice_sum,
  input  logic             slice_cout,
  output logic [1:0]       state_dbg
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  // Handshake: start is a request sampled only in IDLE; busy marks RUN;
  // done is a one-cycle pulse and sum stays valid until the next completion.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_next;
  logic             carry;
  logic [CW-1:0]    cnt;

  assign state_dbg = state;

  // The adder only sees live operands while RUN; otherwise it is fed zeros.
  assign slice_a   = (state == RUN) ? a_sh[SLICE-1:0] : '0;
  assign slice_b   = (state == RUN) ? b_sh[SLICE-1:0] : '0;
  assign slice_cin = (state == RUN) ? carry : 1'b0;

  always_comb begin
    acc_next = acc;
    acc_next[int'(cnt)*SLICE +: SLICE] = slice_sum;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      a_sh  <= '0;
      b_sh  <= '0;
      acc   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            acc   <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          acc   <= acc_next;
          carry <= slice_cout;
          a_sh  <= a_sh >> SLICE;
          b_sh  <= b_sh >> SLICE;
          cnt   <= cnt + 1'b1;
          // sum is only ever written with a complete result, never a partial one.
          if (cnt == CW'(NSLICE - 1)) begin
            sum   <= {slice_cout, acc_next};
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_slice_add_sequencer.sv
// Directed bench for slice_add_sequencer with a 4-bit ripple-carry slice model as the external adder.
module tb_slice_add_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        busy;
  logic        done;
  logic [16:0] sum;
  logic [3:0]  slice_a;
  logic [3:0]  slice_b;
  logic        slice_cin;
  logic [3:0]  slice_sum;
  logic        slice_cout;
  logic [1:0]  state_dbg;

  int n_checks = 0;
  int n_pass   = 0;

  slice_add_sequencer #(.WIDTH(16), .SLICE(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .a          (a),
    .b          (b),
    .busy       (busy),
    .done       (done),
    .sum        (sum),
    .slice_a    (slice_a),
    .slice_b    (slice_b),
    .slice_cin  (slice_cin),
    .slice_sum  (slice_sum),
    .slice_cout (slice_cout),
    .state_dbg  (state_dbg)
  );

  // External 4-bit ripple-carry slice
  logic [4:0] slice_full;
  assign slice_full = {1'b0, slice_a} + {1'b0, slice_b} + {4'b0, slice_cin};
  assign slice_sum  = slice_full[3:0];
  assign slice_cout = slice_full[4];

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Starts an add and samples at negedges until done (bounded). Reports RUN cycle count,
  // latency in cycles from the first post-start negedge, per-slice cin bits and slice_a chunks.
  task automatic run_add(input logic [15:0] av, input logic [15:0] bv,
                         output int busy_cnt, output int lat,
                         output logic [3:0] cin_bits, output logic [15:0] a_chunks);
    @(negedge clk);
    a = av; b = bv; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    busy_cnt = 0; lat = 0; cin_bits = '0; a_chunks = '0;
    while (!done && lat < 20) begin
      if (busy && busy_cnt < 4) begin
        cin_bits[busy_cnt] = slice_cin;
        a_chunks[busy_cnt*4 +: 4] = slice_a;
      end
      if (busy) busy_cnt++;
      @(negedge clk);
      lat++;
    end
  endtask

  int          bc, lat, done_cnt, bad, d_idx;
  int          d_at[4];
  logic [3:0]  cins;
  logic [15:0] achk;
  logic [16:0] held;

  initial begin
    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sum", sum, 0);
    check("rst_slices", {slice_a, slice_b, slice_cin}, 0);
    check("rst_state", state_dbg, 0);
    rst = 1'b0;

    // 1: basic add, handshake timing
    run_add(16'h1234, 16'h4321, bc, lat, cins, achk);
    check("t1_done", done, 1);
    check("t1_busy_cycles", bc, 4);
    check("t1_latency", lat, 4);
    check("t1_sum", sum, 17'h05555);
    check("t1_slice_a_seq", achk, 16'h1234);
    check("t1_busy_in_done", busy, 0);
    @(negedge clk);
    check("t1_done_pulse_width", done, 0);

    // 2: carry ripple across slices
    run_add(16'hFFFF, 16'h0001, bc, lat, cins, achk);
    check("t2_cin_seq", cins, 4'b1110);
    check("t2_sum", sum, 17'h10000);

    // 3: max operands then zero
    run_add(16'hFFFF, 16'hFFFF, bc, lat, cins, achk);
    check("t3_sum_max", sum, 17'h1FFFE);
    run_add(16'h0000, 16'h0000, bc, lat, cins, achk);
    check("t3_done_again", done, 1);
    check("t3_sum_zero", sum, 17'h00000);

    // 4: start during RUN is ignored, operand change after capture has no effect
    @(negedge clk);
    a = 16'h1234; b = 16'h4321; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1; a = 16'h0F0F;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    while (!done && lat < 20) begin @(negedge clk); lat++; end
    check("t4_done", done, 1);
    check("t4_sum", sum, 17'h05555);
    done_cnt = 0;
    repeat (12) begin @(negedge clk); if (done) done_cnt++; end
    check("t4_extra_done", done_cnt, 0);
    check("t4_sum_held", sum, 17'h05555);

    // 5: async reset in the 2nd RUN cycle
    @(negedge clk);
    a = 16'hAAAA; b = 16'h5555; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("t5_running", busy, 1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("t5_rst_busy", busy, 0);
    check("t5_rst_done", done, 0);
    check("t5_rst_sum", sum, 0);
    check("t5_rst_slices", {slice_a, slice_b, slice_cin}, 0);
    @(negedge clk);
    rst = 1'b0;
    run_add(16'h0001, 16'h0002, bc, lat, cins, achk);
    check("t5_sum_after", sum, 17'h00003);

    // 6: start held high re-triggers every 6 cycles, sum stable between completions
    repeat (3) @(negedge clk);
    a = 16'h1111; b = 16'h2222; start = 1'b1;
    d_idx = 0; bad = 0; held = sum;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done) begin
        if (d_idx < 4) d_at[d_idx] = i;
        d_idx++;
        held = sum;
      end else if (d_idx > 0 && sum !== held) bad++;
    end
    start = 1'b0;
    check("t6_done_count", d_idx, 5);
    check("t6_period_a", d_at[1] - d_at[0], 6);
    check("t6_period_b", d_at[2] - d_at[1], 6);
    check("t6_period_c", d_at[3] - d_at[2], 6);
    check("t6_sum", held, 17'h03333);
    check("t6_sum_stable", bad, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
